// File: rtl/amber_tb_pkg.sv
// Shared types and constants for the Amber Wishbone responder stub.
package amber_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_resp_state_e;

    // MOV r0,r0: harmless filler the core executes when the queue runs dry
    localparam logic [31:0] AMBER_NOP = 32'hE1A00000;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_wr_rec_t;

endpackage

// File: rtl/amber_sync_fifo.sv
// Single-clock FIFO with explicit level; full is judged before any same-cycle pop,
// so a push into a full queue is dropped even when a pop happens alongside it.
module amber_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone slave stub: serves core reads from a pushed instruction queue after programmable
// wait states and reports core writes; AMBER_WB_ERR_INJECT_EN adds address-matched error injection.
module amber_wb_responder
    import amber_tb_pkg::*;
#(
    parameter  int          DEPTH    = 16,
    parameter  int          WAIT_W   = 4,
    parameter  logic [31:0] NOP_WORD = AMBER_NOP,
    localparam int          LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    input  logic [WAIT_W-1:0] i_wait_cycles,
    input  logic              i_push_valid,
    input  logic [31:0]       i_push_data,
    output logic              o_push_ready,
    output logic [LVL_W-1:0]  o_fifo_level,
    output logic              o_underflow,
`ifdef AMBER_WB_ERR_INJECT_EN
    input  logic              i_err_en,
    input  logic [31:0]       i_err_adr,
`endif
    output logic              o_wr_valid,
    output logic [31:0]       o_wr_adr,
    output logic [31:0]       o_wr_dat,
    output logic [3:0]        o_wr_sel
);

    wb_resp_state_e    state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    wb_wr_rec_t        req_q, req_d;
    logic              we_q, we_d;
    logic              underflow_q, underflow_d;

    logic              in_ack, err_hit, rd_done, pop;
    logic [31:0]       fifo_head;
    logic              fifo_full, fifo_empty;

    amber_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (i_push_valid),
        .push_dat_i (i_push_data),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .level_o    (o_fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    req_d   = '{adr: i_wb_adr, dat: i_wb_dat, sel: i_wb_sel};
                    we_d    = i_wb_we;
                    cnt_d   = i_wait_cycles;
                    state_d = (i_wait_cycles != '0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                // Master walking away mid-wait cancels the transfer with no side effects
                if (!(i_wb_cyc && i_wb_stb)) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef AMBER_WB_ERR_INJECT_EN
    assign err_hit = i_err_en && (req_q.adr == i_err_adr);
`else
    assign err_hit = 1'b0;
`endif

    assign in_ack       = (state_q == ACK);
    assign o_wb_ack     = in_ack && !err_hit;
    assign o_wb_err     = in_ack && err_hit;
    assign rd_done      = o_wb_ack && !we_q;
    assign pop          = rd_done && !fifo_empty;
    assign o_wb_dat     = rd_done ? (fifo_empty ? NOP_WORD : fifo_head) : '0;
    assign o_push_ready = !fifo_full;
    assign o_underflow  = underflow_q;
    assign underflow_d  = underflow_q || (rd_done && fifo_empty);

    assign o_wr_valid = o_wb_ack && we_q;
    assign o_wr_adr   = o_wr_valid ? req_q.adr : '0;
    assign o_wr_dat   = o_wr_valid ? req_q.dat : '0;
    assign o_wr_sel   = o_wr_valid ? req_q.sel : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            we_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder: queue reads, wait states, abort, writes, wrap, reset.
module tb_amber_wb_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_wb_adr, i_wb_dat, o_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we, i_wb_cyc, i_wb_stb, o_wb_ack, o_wb_err;
    logic [3:0]  i_wait_cycles;
    logic        i_push_valid, o_push_ready, o_underflow;
    logic [31:0] i_push_data;
    logic [4:0]  o_fifo_level;
    logic        o_wr_valid;
    logic [31:0] o_wr_adr, o_wr_dat;
    logic [3:0]  o_wr_sel;
`ifdef AMBER_WB_ERR_INJECT_EN
    logic        i_err_en;
    logic [31:0] i_err_adr;
`endif

    int checks = 0;
    int errors = 0;

    // values observed in the completion cycle of the last transfer
    logic        x_ack, x_err, x_wv;
    logic [31:0] x_rdat, x_wadr, x_wdat;
    logic [3:0]  x_wsel;
    int          x_cyc;

    amber_wb_responder #(.DEPTH(16), .WAIT_W(4), .NOP_WORD(32'hE1A00000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wb_adr      (i_wb_adr),
        .i_wb_sel      (i_wb_sel),
        .i_wb_we       (i_wb_we),
        .i_wb_dat      (i_wb_dat),
        .i_wb_cyc      (i_wb_cyc),
        .i_wb_stb      (i_wb_stb),
        .o_wb_dat      (o_wb_dat),
        .o_wb_ack      (o_wb_ack),
        .o_wb_err      (o_wb_err),
        .i_wait_cycles (i_wait_cycles),
        .i_push_valid  (i_push_valid),
        .i_push_data   (i_push_data),
        .o_push_ready  (o_push_ready),
        .o_fifo_level  (o_fifo_level),
        .o_underflow   (o_underflow),
`ifdef AMBER_WB_ERR_INJECT_EN
        .i_err_en      (i_err_en),
        .i_err_adr     (i_err_adr),
`endif
        .o_wr_valid    (o_wr_valid),
        .o_wr_adr      (o_wr_adr),
        .o_wr_dat      (o_wr_dat),
        .o_wr_sel      (o_wr_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        i_push_valid = 1'b1;
        i_push_data  = d;
        step();
        i_push_valid = 1'b0;
    endtask

    // Drives one bus transfer, counts edges until ack/err, then releases the bus.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] wt);
        i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        i_wait_cycles = wt;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        x_cyc = 0; x_ack = 1'b0; x_err = 1'b0; x_rdat = '0;
        x_wv = 1'b0; x_wadr = '0; x_wdat = '0; x_wsel = '0;
        while (x_cyc < 32) begin
            step();
            x_cyc++;
            if (o_wb_ack || o_wb_err) break;
        end
        if (!(o_wb_ack || o_wb_err)) x_cyc = 99;
        x_ack = o_wb_ack; x_err = o_wb_err; x_rdat = o_wb_dat;
        x_wv = o_wr_valid; x_wadr = o_wr_adr; x_wdat = o_wr_dat; x_wsel = o_wr_sel;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] words [3];
        words[0] = 32'hA000_000A; words[1] = 32'hB000_000B; words[2] = 32'hC000_000C;
        rst_n = 1'b0;
        i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wait_cycles = '0;
        i_push_valid = 1'b0; i_push_data = '0;
`ifdef AMBER_WB_ERR_INJECT_EN
        i_err_en = 1'b0; i_err_adr = '0;
`endif
        repeat (3) step();
        chk("rst_ack", {31'b0, o_wb_ack}, 32'd0);
        chk("rst_err", {31'b0, o_wb_err}, 32'd0);
        chk("rst_wr_valid", {31'b0, o_wr_valid}, 32'd0);
        chk("rst_underflow", {31'b0, o_underflow}, 32'd0);
        chk("rst_wb_dat", o_wb_dat, 32'd0);
        chk("rst_wr_adr", o_wr_adr, 32'd0);
        chk("rst_level", {27'b0, o_fifo_level}, 32'd0);
        chk("rst_push_ready", {31'b0, o_push_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // 1: three queued words, zero wait
        for (int i = 0; i < 3; i++) push_word(words[i]);
        chk("t1_level3", {27'b0, o_fifo_level}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, 32'h0000_0010 + 32'(4 * i), 32'd0, 4'hF, 4'd0);
            chk("t1_latency", 32'(x_cyc), 32'd1);
            chk("t1_ack", {31'b0, x_ack}, 32'd1);
            chk("t1_data", x_rdat, words[i]);
            chk("t1_ack_drop", {31'b0, o_wb_ack}, 32'd0);
            chk("t1_level", {27'b0, o_fifo_level}, 32'(2 - i));
        end
        chk("t1_no_underflow", {31'b0, o_underflow}, 32'd0);

        // 2: empty read returns NOP and sets sticky underflow
        xfer(1'b0, 32'h0000_0020, 32'd0, 4'hF, 4'd0);
        chk("t2_nop", x_rdat, 32'hE1A00000);
        chk("t2_underflow", {31'b0, o_underflow}, 32'd1);
        chk("t2_level", {27'b0, o_fifo_level}, 32'd0);
        push_word(32'hD000_000D);
        xfer(1'b0, 32'h0000_0024, 32'd0, 4'hF, 4'd0);
        chk("t2_good_data", x_rdat, 32'hD000_000D);
        chk("t2_underflow_sticky", {31'b0, o_underflow}, 32'd1);

        // 3: wait states and abort
        push_word(32'hE000_000E);
        xfer(1'b0, 32'h0000_0028, 32'd0, 4'hF, 4'd3);
        chk("t3_latency", 32'(x_cyc), 32'd4);
        chk("t3_data", x_rdat, 32'hE000_000E);
        push_word(32'hF000_000F);
        i_wb_we = 1'b0; i_wb_adr = 32'h0000_002C; i_wait_cycles = 4'd3;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        step();
        chk("t3_abort_ack_a", {31'b0, o_wb_ack}, 32'd0);
        step();
        chk("t3_abort_ack_b", {31'b0, o_wb_ack}, 32'd0);
        i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_abort_quiet", {31'b0, o_wb_ack}, 32'd0);
        end
        chk("t3_abort_level", {27'b0, o_fifo_level}, 32'd1);
        xfer(1'b0, 32'h0000_002C, 32'd0, 4'hF, 4'd0);
        chk("t3_after_abort_data", x_rdat, 32'hF000_000F);

        // 4: write capture
        xfer(1'b1, 32'h0000_0100, 32'hDEADBEEF, 4'hF, 4'd0);
        chk("t4_ack", {31'b0, x_ack}, 32'd1);
        chk("t4_wr_valid", {31'b0, x_wv}, 32'd1);
        chk("t4_wr_adr", x_wadr, 32'h0000_0100);
        chk("t4_wr_dat", x_wdat, 32'hDEADBEEF);
        chk("t4_wr_sel", {28'b0, x_wsel}, 32'hF);
        chk("t4_rd_dat_zero", x_rdat, 32'd0);
        chk("t4_wr_valid_drop", {31'b0, o_wr_valid}, 32'd0);
        chk("t4_level", {27'b0, o_fifo_level}, 32'd0);

        // 5: full queue, dropped push alongside a pop, wrap
        for (int i = 0; i < 16; i++) push_word(32'h0000_1000 + 32'(i));
        chk("t5_level_full", {27'b0, o_fifo_level}, 32'd16);
        chk("t5_not_ready", {31'b0, o_push_ready}, 32'd0);
        i_wb_we = 1'b0; i_wb_adr = 32'h0000_0030; i_wait_cycles = 4'd0;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        step();
        chk("t5_pop_ack", {31'b0, o_wb_ack}, 32'd1);
        chk("t5_pop_data", o_wb_dat, 32'h0000_1000);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        i_push_valid = 1'b1; i_push_data = 32'h0000_5A5A;
        step();
        i_push_valid = 1'b0;
        chk("t5_drop_level", {27'b0, o_fifo_level}, 32'd15);
        push_word(32'h0000_5A5A);
        chk("t5_refill_level", {27'b0, o_fifo_level}, 32'd16);
        for (int i = 1; i < 16; i++) begin
            xfer(1'b0, 32'h0000_0030, 32'd0, 4'hF, 4'd0);
            chk("t5_order", x_rdat, 32'h0000_1000 + 32'(i));
        end
        xfer(1'b0, 32'h0000_0030, 32'd0, 4'hF, 4'd0);
        chk("t5_x_last", x_rdat, 32'h0000_5A5A);
        chk("t5_level_empty", {27'b0, o_fifo_level}, 32'd0);

`ifdef AMBER_WB_ERR_INJECT_EN
        // 6a: error injection
        i_err_en = 1'b1; i_err_adr = 32'h0000_0200;
        push_word(32'h0000_6060);
        xfer(1'b0, 32'h0000_0200, 32'd0, 4'hF, 4'd0);
        chk("t6_err", {31'b0, x_err}, 32'd1);
        chk("t6_no_ack", {31'b0, x_ack}, 32'd0);
        chk("t6_err_latency", 32'(x_cyc), 32'd1);
        chk("t6_no_pop", {27'b0, o_fifo_level}, 32'd1);
        xfer(1'b0, 32'h0000_0204, 32'd0, 4'hF, 4'd0);
        chk("t6_other_ack", {31'b0, x_ack}, 32'd1);
        chk("t6_other_data", x_rdat, 32'h0000_6060);
        i_err_en = 1'b0;
`endif

        // 6b: reset while waiting
        push_word(32'h0000_7070);
        push_word(32'h0000_7171);
        i_wb_we = 1'b0; i_wb_adr = 32'h0000_0040; i_wait_cycles = 4'd5;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        step();
        step();
        chk("t6_wait_no_ack", {31'b0, o_wb_ack}, 32'd0);
        rst_n = 1'b0;
        step();
        chk("t6_rst_ack", {31'b0, o_wb_ack}, 32'd0);
        chk("t6_rst_level", {27'b0, o_fifo_level}, 32'd0);
        chk("t6_rst_underflow", {31'b0, o_underflow}, 32'd0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_post_rst_quiet", {31'b0, o_wb_ack}, 32'd0);
        end
        push_word(32'h0000_8080);
        xfer(1'b0, 32'h0000_0044, 32'd0, 4'hF, 4'd0);
        chk("t6_fresh_data", x_rdat, 32'h0000_8080);
        chk("t6_fresh_latency", 32'(x_cyc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
